// File: rtl/spi_slv_port.sv
// spi_slv_port -- SPI slave (responder) port on the AVR I/O bus.
// ss_n, sck and mosi are oversampled in the cp2 domain. Bytes are shifted
// full-duplex, and the core sees them through SPSCR (control/status) and
// SPSDR (data).
// Build option SPI_SLV_TX_DBL_BUF_EN: SPSDR writes are accepted at any time,
// and SPSCR bit 6 reads TXE (transmit buffer consumed) instead of WCOL.
module spi_slv_port #(
  parameter logic [5:0] SPSCR_Address = 6'h0E,
  parameter logic [5:0] SPSDR_Address = 6'h0F,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] adr,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  input  logic       iore,
  input  logic       iowe,
  output logic       out_en,
  input  logic       irq_ack,
  input  logic       ss_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic                   ss_p0, sck_p0, mosi_p0;
  logic                   ss_p1, sck_p1;
  logic [7:0]             shifter, tx_buf, rx_buf;
  logic [2:0]             bitcnt;
  logic [4:0]             ctrl;
  logic                   spif, flag6, ovr, arm;

  logic spie, dord, cpol, cpha, spe;
  logic lead_e, trail_e, sample_e, shift_e, ss_fall, ss_rise;
  logic scr_sel, sdr_sel, scr_rd, sdr_acc, sdr_wr, clr;
  logic entry_ev, done_ev;

  // Bit presented on miso next: MSB first unless DORD selects LSB first.
  function automatic logic out_bit(input logic [7:0] sh, input logic lsb_first);
    return lsb_first ? sh[0] : sh[7];
  endfunction

  // Shift one received bit in from the end opposite the outgoing bit.
  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b,
                                          input logic lsb_first);
    return lsb_first ? {b, sh[7:1]} : {sh[6:0], b};
  endfunction

  assign spie = ctrl[4];
  assign dord = ctrl[3];
  assign cpol = ctrl[2];
  assign cpha = ctrl[1];
  assign spe  = ctrl[0];

  assign ss_p0   = ss_sync[SYNC_STAGES-1];
  assign sck_p0  = sck_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the CPOL idle level, trailing edge returns to it.
  assign lead_e   = (sck_p1 == cpol) && (sck_p0 != cpol);
  assign trail_e  = (sck_p1 != cpol) && (sck_p0 == cpol);
  assign sample_e = cpha ? trail_e : lead_e;
  assign shift_e  = cpha ? lead_e  : trail_e;
  assign ss_fall  = ss_p1 & ~ss_p0;
  assign ss_rise  = ~ss_p1 & ss_p0;

  assign scr_sel = (adr == SPSCR_Address);
  assign sdr_sel = (adr == SPSDR_Address);
  assign scr_rd  = scr_sel & iore;
  assign sdr_acc = sdr_sel & (iore | iowe);
  assign sdr_wr  = sdr_sel & iowe;
  assign clr     = irq_ack | (arm & sdr_acc);

  assign entry_ev = (state == IDLE) && spe && ss_fall;
  assign done_ev  = (state == DONE) && spe;

  assign out_en = (scr_sel | sdr_sel) & iore;
  assign irq    = spif & spie;

  // Read mux: status register or received byte, zero when not addressed.
  always_comb begin
    dbus_out = 8'h00;
    if (out_en) dbus_out = scr_sel ? {spif, flag6, ovr, ctrl} : rx_buf;
  end

  // Pin synchronisers followed by one edge-detect stage for ss_n and sck.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      ss_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_p1     <= 1'b0;
      sck_p1    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_p1     <= ss_p0;
      sck_p1    <= sck_p0;
    end
  end

  // Transfer FSM: shifter, bit counter and the miso pin driver.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      state   <= IDLE;
      shifter <= 8'h00;
      bitcnt  <= 3'd0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else if (!spe) begin
      state   <= IDLE;
      miso_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            shifter <= tx_buf;
            bitcnt  <= 3'd0;
            miso_oe <= 1'b1;
            state   <= ACTIVE;
            if (!cpha) miso <= out_bit(tx_buf, dord);
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end else if (sample_e) begin
            shifter <= shift_in(shifter, mosi_p0, dord);
            bitcnt  <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= DONE;
          end else if (shift_e) begin
            miso <= out_bit(shifter, dord);
          end
        end
        DONE: begin
`ifdef SPI_SLV_TX_DBL_BUF_EN
          shifter <= flag6 ? 8'h00 : tx_buf;
`else
          shifter <= tx_buf;
`endif
          bitcnt <= 3'd0;
          if (ss_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
          end else begin
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core-visible registers: control, tx/rx buffers and status flags.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      ctrl   <= 5'd0;
      tx_buf <= 8'h00;
      rx_buf <= 8'h00;
      spif   <= 1'b0;
      flag6  <= 1'b0;
      ovr    <= 1'b0;
      arm    <= 1'b0;
    end else begin
      if (iowe && scr_sel) ctrl <= dbus_in[4:0];

      // SPIF clear needs an SPSCR read with SPIF set before the SPSDR access.
      if (clr)                arm <= 1'b0;
      else if (scr_rd && spif) arm <= 1'b1;

      if (done_ev && !spif) rx_buf <= shifter;

      if (done_ev)  spif <= 1'b1;
      else if (clr) spif <= 1'b0;

      if (done_ev && spif) ovr <= 1'b1;
      else if (clr)        ovr <= 1'b0;

`ifdef SPI_SLV_TX_DBL_BUF_EN
      if (sdr_wr) tx_buf <= dbus_in;
      if (entry_ev || done_ev) flag6 <= 1'b1;
      else if (sdr_wr)         flag6 <= 1'b0;
`else
      if (sdr_wr && ss_p0) tx_buf <= dbus_in;
      if (sdr_wr && !ss_p0) flag6 <= 1'b1;
      else if (clr)         flag6 <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slv_port.sv
// tb_spi_slv_port -- randomized bench for spi_slv_port with a register-level
// reference model of the status flags, buffers and transmitted bytes.
module tb_spi_slv_port;

  localparam logic [5:0] SCR = 6'h0E;
  localparam logic [5:0] SDR = 6'h0F;
  localparam int         H   = 6;

  logic       cp2 = 1'b0;
  logic       ireset, iore, iowe, irq_ack, ss_n, sck, mosi;
  logic [5:0] adr;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en, miso, miso_oe, irq;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_tx, m_rx, m_cur;
  logic [4:0] m_ctrl;
  logic       m_spif, m_ovr, m_b6, m_arm, m_ss_low;

  spi_slv_port #(.SPSCR_Address(SCR), .SPSDR_Address(SDR), .SYNC_STAGES(2)) dut (
    .cp2(cp2), .ireset(ireset), .adr(adr), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .iore(iore), .iowe(iowe), .out_en(out_en), .irq_ack(irq_ack), .ss_n(ss_n),
    .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .irq(irq)
  );

  always #5 cp2 = ~cp2;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  function automatic void m_clr();
    m_spif = 1'b0;
    m_ovr  = 1'b0;
`ifndef SPI_SLV_TX_DBL_BUF_EN
    m_b6   = 1'b0;
`endif
    m_arm  = 1'b0;
  endfunction

  function automatic logic [7:0] m_scr();
    return {m_spif, m_b6, m_ovr, m_ctrl};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge cp2);
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge cp2);
    adr = a; dbus_in = d; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0;
    if (a == SCR) m_ctrl = d[4:0];
    if (a == SDR) begin
      if (m_arm) m_clr();
`ifdef SPI_SLV_TX_DBL_BUF_EN
      m_tx = d; m_b6 = 1'b0;
`else
      if (m_ss_low) m_b6 = 1'b1;
      else          m_tx = d;
`endif
    end
  endtask

  task automatic io_rd(input logic [5:0] a, input string tag);
    @(negedge cp2);
    adr = a; iore = 1'b1;
    #1;
    chk(tag, dbus_out, (a == SCR) ? m_scr() : m_rx);
    chk({tag, "_oe"}, {7'd0, out_en}, 8'h01);
    @(negedge cp2);
    iore = 1'b0;
    if (a == SCR && m_spif) m_arm = 1'b1;
    if (a == SDR && m_arm)  m_clr();
  endtask

  task automatic ack();
    @(negedge cp2); irq_ack = 1'b1;
    @(negedge cp2); irq_ack = 1'b0;
    m_clr();
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, {7'd0, irq}, {7'd0, m_spif & m_ctrl[4]});
  endtask

  // Master side of one byte (or a partial byte of nbits bits).
  task automatic spi_bits(input logic [7:0] mtx, input int nbits, output logic [7:0] mrx);
    logic cpol, cpha, dord;
    cpol = m_ctrl[2]; cpha = m_ctrl[1]; dord = m_ctrl[3];
    mrx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int bi;
      bi = dord ? i : 7 - i;
      if (!cpha) begin
        mosi = mtx[bi]; cyc(H);
        sck = ~cpol; mrx[bi] = miso; cyc(H);
        sck = cpol;
      end else begin
        sck = ~cpol; mosi = mtx[bi]; cyc(H);
        sck = cpol; mrx[bi] = miso; cyc(H);
      end
    end
    cyc(H);
  endtask

  task automatic xfer(input logic [7:0] mtx, input string tag, output logic [7:0] mrx);
    spi_bits(mtx, 8, mrx);
    chk({tag, "_miso"}, mrx, m_cur);
    if (m_spif) m_ovr = 1'b1;
    else begin m_rx = mtx; m_spif = 1'b1; end
`ifdef SPI_SLV_TX_DBL_BUF_EN
    m_cur = m_b6 ? 8'h00 : m_tx;
    m_b6  = 1'b1;
`else
    m_cur = m_tx;
`endif
  endtask

  task automatic frame_begin(input string tag);
    sck = m_ctrl[2];
    cyc(H);
    ss_n = 1'b0; m_ss_low = 1'b1;
    m_cur = m_tx;
`ifdef SPI_SLV_TX_DBL_BUF_EN
    m_b6 = 1'b1;
`endif
    cyc(H);
    chk({tag, "_oe_on"}, {7'd0, miso_oe}, 8'h01);
  endtask

  task automatic frame_end(input string tag);
    ss_n = 1'b1; m_ss_low = 1'b0;
    cyc(H);
    chk({tag, "_oe_off"}, {7'd0, miso_oe}, 8'h00);
  endtask

  initial begin
    logic [7:0] r, r2;
    ireset = 1'b1; iore = 1'b0; iowe = 1'b0; irq_ack = 1'b0;
    ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; adr = 6'h00; dbus_in = 8'h00;
    m_tx = 0; m_rx = 0; m_cur = 0; m_ctrl = 0;
    m_spif = 0; m_ovr = 0; m_b6 = 0; m_arm = 0; m_ss_low = 0;
    cyc(3);
    ireset = 1'b0;
    cyc(4);

    // Reset state
    chk("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    chk("rst_miso", {7'd0, miso}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_out_en", {7'd0, out_en}, 8'h00);
    io_rd(SCR, "rst_scr");
    io_rd(SDR, "rst_sdr");

    // Mode 0, MSB first, SPIE set
    io_wr(SCR, 8'h11);
    io_wr(SDR, 8'hA5);
    frame_begin("m0");
    xfer(8'h3C, "m0", r);
    chk("m0_bits", r, 8'hA5);
    frame_end("m0");
    chk_irq("m0_irq");
    chk("m0_irq_set", {7'd0, irq}, 8'h01);
    io_rd(SDR, "m0_sdr");
    io_rd(SCR, "m0_scr");
    ack();
    chk("m0_irq_clr", {7'd0, irq}, 8'h00);
    io_rd(SCR, "m0_scr_ack");

    // Mode 3, LSB first
    io_wr(SCR, 8'h1F);
    io_wr(SDR, 8'h01);
    frame_begin("m3");
    xfer(8'h80, "m3", r);
    chk("m3_first", {7'd0, r[0]}, 8'h01);
    frame_end("m3");
    io_rd(SCR, "m3_scr");
    io_rd(SDR, "m3_sdr");
    chk("m3_rx", m_rx, 8'h80);
    io_rd(SCR, "m3_scr_clr");

    // Overrun: two bytes without reading SPSDR
    io_wr(SCR, 8'h01);
    io_wr(SDR, 8'h5A);
    frame_begin("ovr");
    xfer(8'h11, "ovr1", r);
    xfer(8'h22, "ovr2", r);
    frame_end("ovr");
    io_rd(SCR, "ovr_scr");
    io_rd(SDR, "ovr_sdr");
    io_rd(SCR, "ovr_scr_clr");
    chk("ovr_flag_cleared", {7'd0, m_ovr}, 8'h00);

    // Aborted partial byte, then a full byte
    frame_begin("part");
    spi_bits(8'hF0, 2, r);
    frame_end("part");
    io_rd(SCR, "part_scr");
    frame_begin("full");
    xfer(8'h96, "full", r);
    frame_end("full");
    io_rd(SCR, "full_scr");
    io_rd(SDR, "full_sdr");

    // SPSDR write while selected
    io_wr(SDR, 8'hC3);
    frame_begin("wcol");
    io_wr(SDR, 8'h55);
    xfer(8'h0F, "wcol1", r);
    xfer(8'hF0, "wcol2", r2);
    frame_end("wcol");
`ifdef SPI_SLV_TX_DBL_BUF_EN
    chk("wcol_byte2", r2, 8'h55);
`else
    chk("wcol_byte2", r2, 8'hC3);
`endif
    io_rd(SCR, "wcol_scr");
    io_rd(SDR, "wcol_sdr");
    io_rd(SCR, "wcol_scr_clr");

    // Randomized frames against the model
    for (int it = 0; it < 24; it++) begin
      logic [7:0] c;
      int nb, act;
      c = {3'b000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      io_wr(SCR, c);
      io_wr(SDR, 8'($urandom));
      nb = $urandom_range(1, 3);
      frame_begin("rnd");
      for (int b = 0; b < nb; b++) xfer(8'($urandom), "rnd", r);
      frame_end("rnd");
      chk_irq("rnd_irq");
      io_rd(SCR, "rnd_scr");
      act = $urandom_range(0, 3);
      if (act == 1) ack();
      else if (act >= 2) io_rd(SDR, "rnd_sdr");
      chk_irq("rnd_irq2");
      io_rd(SCR, "rnd_scr2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
